// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 fetch definitions: instruction codes, status codes, the
// fetch-stage state encoding and small decode helpers (instruction length and
// register-byte presence) used by the fetch stage.
// No ports (package).
// -----------------------------------------------------------------------------
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        FS_LOAD = 2'd0,
        FS_RUN  = 2'd1,
        FS_STOP = 2'd2
    } fetch_state_e;

    // Instruction length in bytes. Undefined icodes are given length 1 so
    // that valP and the address check stay well defined; they report INS.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            I_HALT, I_NOP, I_RET:                 instr_len = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:     instr_len = 4'd2;
            I_JXX, I_CALL:                        instr_len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:         instr_len = 4'd10;
            default:                              instr_len = 4'd1;
        endcase
    endfunction

    // True when byte 1 of the instruction carries the rA/rB fields.
    function automatic logic has_regbyte(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ:               has_regbyte = 1'b1;
            default:                              has_regbyte = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_stage_imem.sv
// -----------------------------------------------------------------------------
// imem
// Byte-wide instruction memory with one synchronous write port and ten
// combinational read bytes at raddr_i .. raddr_i+9 (byte k at rdata_o[8k+:8]).
// Bytes whose address falls at or beyond MEM_BYTES read as zero and never
// index the array. Contents have no reset.
// Ports:
//   clk      - clock
//   we_i     - byte write enable
//   waddr_i  - byte write address (AW bits)
//   wdata_i  - byte write data
//   raddr_i  - 64-bit read base address (the PC)
//   rdata_o  - 80 bits: ten bytes starting at raddr_i
// -----------------------------------------------------------------------------
module imem #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [63:0]   raddr_i,
    output logic [79:0]   rdata_o
);

    logic [7:0] mem_q [MEM_BYTES];

    // Byte write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // 65-bit address sum so a PC near 2^64 cannot wrap back into the array.
    for (genvar k = 0; k < 10; k++) begin : g_rd
        logic [64:0] addr_s;
        assign addr_s = {1'b0, raddr_i} + 65'(k);
        assign rdata_o[8*k +: 8] = (addr_s < 65'(MEM_BYTES)) ? mem_q[addr_s[AW-1:0]] : 8'h00;
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Y86-64 fetch stage with an instruction-memory load phase. States:
// LOAD (memory writable, pc held at 0, outputs forced to an inert nop),
// RUN (pc follows updated_pc while status is AOK) and STOP (frozen until
// reset). Decode is combinational from the PC register.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   start                - leave LOAD and run from pc 0
//   imem_we/addr/wdata   - byte writes into instruction memory (LOAD only)
//   updated_pc           - next PC from the pc_update stage
//   pc                   - current PC register
//   icode/ifun/rA/rB     - instruction fields
//   valC, valP           - constant word and fall-through PC
//   stat                 - 1 AOK, 2 HLT, 3 ADR, 4 INS
//   running              - high in RUN
// -----------------------------------------------------------------------------
module fetch_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          imem_we,
    input  logic [AW-1:0] imem_addr,
    input  logic [7:0]    imem_wdata,
    input  logic [63:0]   updated_pc,
    output logic [63:0]   pc,
    output logic [3:0]    icode,
    output logic [3:0]    ifun,
    output logic [3:0]    rA,
    output logic [3:0]    rB,
    output logic [63:0]   valC,
    output logic [63:0]   valP,
    output logic [2:0]    stat,
    output logic          running
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;

    logic         mem_we_s;
    logic [79:0]  ibytes_s;
    logic [3:0]   icode_s, ifun_s, ra_s, rb_s, len_s;
    logic [63:0]  valc_s, valp_s;
    logic [64:0]  end_s;
    logic [2:0]   stat_s;

    // Writes are blocked during reset and outside LOAD.
    assign mem_we_s = rst_n && imem_we && (state_q == FS_LOAD);

    imem #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_imem (
        .clk     (clk),
        .we_i    (mem_we_s),
        .waddr_i (imem_addr),
        .wdata_i (imem_wdata),
        .raddr_i (pc_q),
        .rdata_o (ibytes_s)
    );

    // Instruction decode, length, valC/valP and status from the current PC.
    always_comb begin
        icode_s = ibytes_s[7:4];
        ifun_s  = ibytes_s[3:0];
        len_s   = instr_len(icode_s);
        if (has_regbyte(icode_s)) begin
            ra_s = ibytes_s[15:12];
            rb_s = ibytes_s[11:8];
        end else begin
            ra_s = REG_NONE;
            rb_s = REG_NONE;
        end
        case (icode_s)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: valc_s = ibytes_s[79:16];
            I_JXX, I_CALL:                valc_s = ibytes_s[71:8];
            default:                      valc_s = 64'd0;
        endcase
        valp_s = pc_q + {60'd0, len_s};
        // Extra bit keeps the end-of-instruction compare exact near 2^64.
        end_s  = {1'b0, pc_q} + {61'd0, len_s};
        if (end_s > 65'(MEM_BYTES)) begin
            stat_s = STAT_ADR;
        end else if (icode_s > I_POPQ) begin
            stat_s = STAT_INS;
        end else if (icode_s == I_HALT) begin
            stat_s = STAT_HLT;
        end else begin
            stat_s = STAT_AOK;
        end
    end

    // Output muxes: LOAD presents an inert nop downstream.
    always_comb begin
        pc      = pc_q;
        running = (state_q == FS_RUN);
        if (state_q == FS_LOAD) begin
            icode = I_NOP;
            ifun  = 4'h0;
            rA    = REG_NONE;
            rB    = REG_NONE;
            valC  = 64'd0;
            valP  = 64'd0;
            stat  = STAT_AOK;
        end else begin
            icode = icode_s;
            ifun  = ifun_s;
            rA    = ra_s;
            rB    = rb_s;
            valC  = valc_s;
            valP  = valp_s;
            stat  = stat_s;
        end
    end

    // Next-state and next-PC logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            FS_LOAD: begin
                pc_d = 64'd0;
                if (start) begin
                    state_d = FS_RUN;
                end else begin
                    state_d = FS_LOAD;
                end
            end
            FS_RUN: begin
                if (stat_s == STAT_AOK) begin
                    pc_d = updated_pc;
                end else begin
                    state_d = FS_STOP;
                end
            end
            FS_STOP: begin
                state_d = FS_STOP;
            end
            default: begin
                state_d = FS_LOAD;
                pc_d    = 64'd0;
            end
        endcase
    end

    // State and PC registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FS_LOAD;
            pc_q    <= 64'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stimulus compared against a behavioural model (byte array, run state, PC).
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n, start, imem_we;
    logic [9:0]  imem_addr;
    logic [7:0]  imem_wdata;
    logic [63:0] updated_pc;
    logic [63:0] pc, valC, valP;
    logic [3:0]  icode, ifun, rA, rB;
    logic [2:0]  stat;
    logic        running;

    int checks   = 0;
    int failures = 0;

    fetch_stage #(.MEM_BYTES(1024), .AW(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .updated_pc (updated_pc),
        .pc         (pc),
        .icode      (icode),
        .ifun       (ifun),
        .rA         (rA),
        .rB         (rB),
        .valC       (valC),
        .valP       (valP),
        .stat       (stat),
        .running    (running)
    );

    always #5 clk = ~clk;

    logic [211:0] dut_vec;
    assign dut_vec = {pc, icode, ifun, rA, rB, valC, valP, stat, running};

    // Reference model: memory image, run state (0 load, 1 run, 2 stop), PC.
    logic [7:0]  mm [1024];
    int          m_state;
    logic [63:0] m_pc;

    function automatic logic [7:0] mbyte(input logic [63:0] a, input int k);
        logic [64:0] s;
        s = {1'b0, a} + 65'(k);
        if (s < 65'd1024) return mm[s[9:0]];
        return 8'h00;
    endfunction

    function automatic logic [211:0] exp_vec();
        logic [7:0]  b0, b1;
        logic [3:0]  ic, fn, ra, rb;
        logic [63:0] vc, vp;
        logic [64:0] endp;
        logic [2:0]  st;
        int          len;
        if (m_state == 0)
            return {64'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1, 1'b0};
        b0 = mbyte(m_pc, 0);
        ic = b0[7:4];
        fn = b0[3:0];
        if (ic inside {4'h0, 4'h1, 4'h9})              len = 1;
        else if (ic inside {4'h2, 4'h6, 4'hA, 4'hB})   len = 2;
        else if (ic inside {4'h7, 4'h8})               len = 9;
        else if (ic inside {4'h3, 4'h4, 4'h5})         len = 10;
        else                                           len = 1;
        ra = 4'hF;
        rb = 4'hF;
        if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
            b1 = mbyte(m_pc, 1);
            ra = b1[7:4];
            rb = b1[3:0];
        end
        vc = 64'd0;
        if (ic inside {4'h3, 4'h4, 4'h5})
            for (int k = 0; k < 8; k++) vc[8*k +: 8] = mbyte(m_pc, k + 2);
        else if (ic inside {4'h7, 4'h8})
            for (int k = 0; k < 8; k++) vc[8*k +: 8] = mbyte(m_pc, k + 1);
        vp   = m_pc + 64'(len);
        endp = {1'b0, m_pc} + 65'(len);
        if (endp > 65'd1024)  st = 3'd3;
        else if (ic > 4'hB)   st = 3'd4;
        else if (ic == 4'h0)  st = 3'd2;
        else                  st = 3'd1;
        return {m_pc, ic, fn, ra, rb, vc, vp, st, (m_state == 1)};
    endfunction

    // Advance model with the current inputs, then one clock edge.
    task automatic tick();
        logic [211:0] v;
        v = exp_vec();
        if (!rst_n) begin
            m_state = 0;
            m_pc    = 64'd0;
        end else begin
            case (m_state)
                0: begin
                    if (imem_we) mm[imem_addr] = imem_wdata;
                    if (start) m_state = 1;
                    m_pc = 64'd0;
                end
                1: begin
                    if (v[3:1] == 3'd1) m_pc = updated_pc;
                    else m_state = 2;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; imem_we = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic write_byte(input logic [9:0] a, input logic [7:0] d);
        imem_we = 1'b1; imem_addr = a; imem_wdata = d;
        tick();
        imem_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; imem_we = 1'b0; updated_pc = 64'd77;
        imem_addr = 10'd0; imem_wdata = 8'd0;
        tick(); tick();
        start = 1'b0;
        checks++;
        if ({pc, running} !== {64'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_pc_running got pc=%0d running=%b exp pc=0 running=0", pc, running);
        end
        checks++;
        if ({icode, ifun, rA, rB, valC, valP, stat} !== {4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1}) begin
            failures++;
            $display("FAIL reset_forced got icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h stat=%0d",
                     icode, ifun, rA, rB, valC, valP, stat);
        end
        rst_n = 1'b1;
        // Zero the whole memory so DUT and model start from the same image.
        for (int a = 0; a < 1024; a++) write_byte(10'(a), 8'h00);
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL reset_model got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_two_instr();
        do_reset();
        write_byte(10'd0, 8'h30); write_byte(10'd1, 8'hF2); write_byte(10'd2, 8'h00);
        start = 1'b1; updated_pc = 64'd10;
        tick();
        start = 1'b0;
        checks++;
        if ({pc, icode, rB, valP, stat, running} !== {64'd0, 4'h3, 4'h2, 64'd10, 3'd1, 1'b1}) begin
            failures++;
            $display("FAIL two_instr_c1 got pc=%0d icode=%h rB=%h valP=%0d stat=%0d running=%b exp 0 3 2 10 1 1",
                     pc, icode, rB, valP, stat, running);
        end
        tick();
        checks++;
        if ({pc, stat, running} !== {64'd10, 3'd2, 1'b1}) begin
            failures++;
            $display("FAIL two_instr_c2 got pc=%0d stat=%0d running=%b exp pc=10 stat=2 running=1", pc, stat, running);
        end
        tick();
        checks++;
        if ({pc, running} !== {64'd10, 1'b0}) begin
            failures++;
            $display("FAIL two_instr_stop got pc=%0d running=%b exp pc=10 running=0", pc, running);
        end
    endtask

    task automatic test_jump();
        do_reset();
        write_byte(10'd0, 8'h70); write_byte(10'd1, 8'h40);
        for (int a = 2; a <= 8; a++) write_byte(10'(a), 8'h00);
        start = 1'b1; updated_pc = 64'd9;
        tick();
        start = 1'b0;
        checks++;
        if ({icode, valC, valP, rA, rB, stat} !== {4'h7, 64'h40, 64'd9, 4'hF, 4'hF, 3'd1}) begin
            failures++;
            $display("FAIL jump_decode got icode=%h valC=%h valP=%0d rA=%h rB=%h stat=%0d exp 7 40 9 f f 1",
                     icode, valC, valP, rA, rB, stat);
        end
    endtask

    task automatic test_ins();
        do_reset();
        write_byte(10'd0, 8'hC0);
        start = 1'b1; updated_pc = 64'h123;
        tick();
        start = 1'b0;
        checks++;
        if ({pc, stat, running} !== {64'd0, 3'd4, 1'b1}) begin
            failures++;
            $display("FAIL ins_stat got pc=%0d stat=%0d running=%b exp pc=0 stat=4 running=1", pc, stat, running);
        end
        tick();
        start = 1'b1; imem_we = 1'b1; imem_addr = 10'd0; imem_wdata = 8'h10;
        tick(); tick();
        start = 1'b0; imem_we = 1'b0;
        checks++;
        if ({pc, icode, stat, running} !== {64'd0, 4'hC, 3'd4, 1'b0}) begin
            failures++;
            $display("FAIL ins_stop_frozen got pc=%0d icode=%h stat=%0d running=%b exp pc=0 icode=c stat=4 running=0",
                     pc, icode, stat, running);
        end
    endtask

    task automatic test_adr();
        do_reset();
        write_byte(10'd0, 8'h10); write_byte(10'd1020, 8'h30);
        start = 1'b1; updated_pc = 64'd1020;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if ({pc, icode, valP, stat} !== {64'd1020, 4'h3, 64'd1030, 3'd3}) begin
            failures++;
            $display("FAIL adr_overrun got pc=%0d icode=%h valP=%0d stat=%0d exp pc=1020 icode=3 valP=1030 stat=3",
                     pc, icode, valP, stat);
        end
        tick();
        checks++;
        if ({pc, running} !== {64'd1020, 1'b0}) begin
            failures++;
            $display("FAIL adr_stop got pc=%0d running=%b exp pc=1020 running=0", pc, running);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        write_byte(10'd0, 8'h60); write_byte(10'd1, 8'h12); write_byte(10'd20, 8'h10);
        start = 1'b1; updated_pc = 64'd20;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if ({pc, icode, running} !== {64'd20, 4'h1, 1'b1}) begin
            failures++;
            $display("FAIL midrun_at20 got pc=%0d icode=%h running=%b exp pc=20 icode=1 running=1", pc, icode, running);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({pc, running, icode, rA, rB, valP, stat} !== {64'd0, 1'b0, 4'h1, 4'hF, 4'hF, 64'd0, 3'd1}) begin
            failures++;
            $display("FAIL midrun_reset got pc=%0d running=%b icode=%h rA=%h rB=%h valP=%0d stat=%0d",
                     pc, running, icode, rA, rB, valP, stat);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({pc, running, icode, ifun, rA, rB, valP} !== {64'd0, 1'b1, 4'h6, 4'h0, 4'h1, 4'h2, 64'd2}) begin
            failures++;
            $display("FAIL midrun_rerun got pc=%0d running=%b icode=%h ifun=%h rA=%h rB=%h valP=%0d exp 0 1 6 0 1 2 2",
                     pc, running, icode, ifun, rA, rB, valP);
        end
    endtask

    task automatic test_start_with_we();
        do_reset();
        imem_we = 1'b1; imem_addr = 10'd5; imem_wdata = 8'h90;
        start = 1'b1; updated_pc = 64'd5;
        tick();
        imem_we = 1'b0; start = 1'b0;
        checks++;
        if ({pc, running} !== {64'd0, 1'b1}) begin
            failures++;
            $display("FAIL start_we_run got pc=%0d running=%b exp pc=0 running=1", pc, running);
        end
        tick();
        checks++;
        if ({pc, icode, valP, stat} !== {64'd5, 4'h9, 64'd6, 3'd1}) begin
            failures++;
            $display("FAIL start_we_byte got pc=%0d icode=%h valP=%0d stat=%0d exp pc=5 icode=9 valP=6 stat=1",
                     pc, icode, valP, stat);
        end
    endtask

    task automatic test_random();
        logic [3:0] hi;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 29) != 0);
            start   = ($urandom_range(0, 3) == 0);
            imem_we = ($urandom_range(0, 1) == 1);
            imem_addr = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 63));
            hi = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(1, 11));
            imem_wdata = {hi, 4'($urandom)};
            case ($urandom_range(0, 9))
                0:       updated_pc = {$urandom, $urandom};
                1, 2:    updated_pc = 64'($urandom_range(1010, 1030));
                default: updated_pc = 64'($urandom_range(0, 63));
            endcase
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random_cyc%0d got %h exp %h", i, dut_vec, exp_vec());
            end
        end
        rst_n = 1'b1; start = 1'b0; imem_we = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) mm[a] = 8'h00;
        m_state = 0;
        m_pc    = 64'd0;
        test_reset();
        test_two_instr();
        test_jump();
        test_ins();
        test_adr();
        test_reset_mid_run();
        test_start_with_we();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter MEM_BYTES, default 1024, instruction-memory size in bytes (power of two).
REQ-002 Parameter AW, default 10, imem load-address width, log2(MEM_BYTES).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  leaves LOAD and begins execution at PC 0.
REQ-006 imem_we  input  1  byte write strobe into instruction memory; honoured in LOAD only.
REQ-007 imem_addr  input  AW  byte write address.
REQ-008 imem_wdata  input  8  byte write data.
REQ-009 updated_pc  input  64  next PC from the pc_update stage.
REQ-010 pc  output  64  current PC register.
REQ-011 icode, ifun, rA, rB  output  4 each  fields of the instruction at pc.
REQ-012 valC  output  64  constant word, little-endian; 0 when absent.
REQ-013 valP  output  64  pc plus instruction length.
REQ-014 stat  output  3  1 AOK, 2 HLT, 3 ADR, 4 INS.
REQ-015 running  output  1  high only in state RUN.

Function
REQ-016 States LOAD, RUN and STOP; reset enters LOAD.
REQ-017 LOAD: imem_we writes imem_wdata to byte imem_addr each cycle; pc holds 0; start moves to RUN next cycle.
REQ-018 A start coincident with imem_we performs the write and the transition in the same cycle.
REQ-019 RUN: each cycle pc loads updated_pc when stat is AOK; otherwise pc holds and state moves to STOP.
REQ-020 STOP: pc and stat frozen; only reset exits; start and imem_we ignored.
REQ-021 Decode is combinational from pc: byte0 gives icode[7:4] and ifun[3:0]; byte1 gives rA[7:4] and rB[3:0] when the instruction has a register byte, else rA = rB = 0xF.
REQ-022 Lengths: icode 0, 1, 9 take 1 byte; 2, 6, A, B take 2; 7, 8 take 9; 3, 4, 5 take 10.
REQ-023 valC is bytes 2..9 for icode 3, 4, 5 and bytes 1..8 for icode 7, 8; 64-bit addition, no wrap check on valP.
REQ-024 stat priority, highest first: ADR when pc + length > MEM_BYTES; then INS when icode > 0xB; then HLT when icode == 0; else AOK.
REQ-025 Out-of-range bytes read as 0 and never index the array.
REQ-026 In LOAD, outputs are forced to icode 1, ifun 0, rA = rB = 0xF, valC 0, valP 0 and stat AOK, so downstream stays inert.
REQ-027 Throughput is one instruction per cycle; pc to decode outputs adds zero latency.

Reset
REQ-028 When rst_n is low at a clock edge: state LOAD, pc 0, running 0; this takes precedence over all other inputs.
REQ-029 Reset asserted mid-RUN or in STOP returns the block to LOAD in one cycle.
REQ-030 Memory contents are not cleared by reset.

Structure
REQ-031 Package y86_pkg holds the icode constants (HALT 0 through POPQ B), the stat codes, the instruction-length function and the fetch state enum.
REQ-032 Sub-module imem: byte array with one write port and ten combinational read bytes at pc..pc+9.
REQ-033 fetch_stage contains the state machine, PC register, length/valC/stat logic and the LOAD forcing muxes.

Verification
REQ-034 Load 30 F2 at 0 and 00 at 2, start, feed updated_pc = valP -> cycle 1: pc 0, icode 3, rB 2, valP 10; cycle 2: pc 10, stat HLT; next cycle running 0 and pc stays 10.
REQ-035 Load 70 plus 8-byte 0x0000000000000040 at 0, start -> icode 7, valC 0x40, valP 9, rA = rB = 0xF.
REQ-036 Byte 0xC0 at pc 0 -> stat INS, then STOP with pc 0; a later start is ignored.
REQ-037 Byte 0x30 at address 1020 (10-byte instruction overruns 1024) -> stat ADR, not INS.
REQ-038 rst_n low for one cycle during RUN at pc 20 -> next cycle state LOAD, pc 0, outputs forced to nop, memory bytes intact on rerun.
REQ-039 start and imem_we together at address 5 -> byte 5 written and RUN entered on the same edge.
